user_io_host: RTL

- SPI master that drives the core-side configuration SPI link (SPI_SCK, SPI_DI, SPI_DO, CONF_DATA0) from the IO-controller end.
- Issues one command byte followed by N data bytes per transaction. Returns each byte shifted back from the core.
- Used as the IO-controller model in system simulation, and on boards without the ARM controller. Provides the opposite end of the core's user_io slave.

---
 rtl/user_io_host.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/user_io_host.sv
`default_nettype none
// ============================================================================
// Module  : user_io_host
// Brief   : SPI mode-0 master that drives the core configuration link. Each
//           transaction sends a command byte plus len data bytes, MSB first.
// Revision: 1.0
// ============================================================================
module user_io_host #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [7:0] len,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       SPI_SCK,
    output logic       SPI_DI,
    input  logic       SPI_DO,
    output logic       CONF_DATA0
);

    localparam int              CW     = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   c_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   c_PRE  = CW'(CLK_DIV - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [2:0]      r_bit, w_bit;
    logic [7:0]      r_byte, w_byte;
    logic [7:0]      r_len, w_len;
    logic [7:0]      r_tx, w_tx;
    logic [7:0]      r_rx, w_rx;
    logic [7:0]      r_rd_data, w_rd_data;
    logic            r_rd_valid, w_rd_valid;
    logic            r_wr_ack, w_wr_ack;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic            r_sck, w_sck;
    logic            r_di, w_di;
    logic            r_cs_n, w_cs_n;
    logic [7:0]      w_rx_shift;

    assign w_rx_shift = {r_rx[6:0], SPI_DO};

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt + 1'b1;
        w_bit      = r_bit;
        w_byte     = r_byte;
        w_len      = r_len;
        w_tx       = r_tx;
        w_rx       = r_rx;
        w_rd_data  = r_rd_data;
        w_rd_valid = 1'b0;
        w_wr_ack   = 1'b0;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_sck      = r_sck;
        w_di       = r_di;
        w_cs_n     = r_cs_n;

        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (start) begin
                    w_state = S_SETUP;
                    w_len   = len;
                    w_tx    = cmd;
                    w_di    = cmd[7];
                    w_cs_n  = 1'b0;
                    w_busy  = 1'b1;
                    w_bit   = 3'd7;
                    w_byte  = 8'd0;
                end
            end
            S_SETUP: begin
                if (r_cnt == c_LAST) begin
                    w_cnt   = '0;
                    w_sck   = 1'b1;
                    w_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_sck) begin
                    // MISO is captured in the first cycle of each high half.
                    if (r_cnt == '0) begin
                        w_rx = w_rx_shift;
                        if (r_bit == 3'd0 && r_byte != 8'd0) begin
                            w_rd_data  = w_rx_shift;
                            w_rd_valid = 1'b1;
                        end
                    end
                    // Ack is raised one cycle early so it covers the load cycle.
                    if (r_cnt == c_PRE && r_bit == 3'd0 && r_byte != r_len)
                        w_wr_ack = 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_cnt = '0;
                        w_sck = 1'b0;
                        if (r_bit != 3'd0) begin
                            w_tx = {r_tx[6:0], 1'b0};
                            w_di = r_tx[6];
                        end else if (r_byte != r_len) begin
                            w_tx = wr_data;
                            w_di = wr_data[7];
                        end
                    end
                end else if (r_cnt == c_LAST) begin
                    w_cnt = '0;
                    if (r_bit == 3'd0 && r_byte == r_len) begin
                        w_state = S_HOLD;
                    end else begin
                        w_sck = 1'b1;
                        w_bit = r_bit - 3'd1;
                        if (r_bit == 3'd0)
                            w_byte = r_byte + 8'd1;
                    end
                end
            end
            S_HOLD: begin
                if (r_cnt == c_LAST) begin
                    w_cnt   = '0;
                    w_cs_n  = 1'b1;
                    w_state = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == c_PRE) begin
                    w_done = 1'b1;
                    w_busy = 1'b0;
                end
                if (r_cnt == c_LAST) begin
                    w_cnt   = '0;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= 3'd7;
            r_byte     <= 8'd0;
            r_len      <= 8'd0;
            r_tx       <= 8'd0;
            r_rx       <= 8'd0;
            r_rd_data  <= 8'd0;
            r_rd_valid <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sck      <= 1'b0;
            r_di       <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bit      <= w_bit;
            r_byte     <= w_byte;
            r_len      <= w_len;
            r_tx       <= w_tx;
            r_rx       <= w_rx;
            r_rd_data  <= w_rd_data;
            r_rd_valid <= w_rd_valid;
            r_wr_ack   <= w_wr_ack;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_sck      <= w_sck;
            r_di       <= w_di;
            r_cs_n     <= w_cs_n;
        end
    end

    assign wr_ack     = r_wr_ack;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign SPI_SCK    = r_sck;
    assign SPI_DI     = r_di;
    assign CONF_DATA0 = r_cs_n;

endmodule
`default_nettype wire
